// File: rtl/arith_pkg.sv
// Shared arithmetic package: default operand width and sequencer state encoding.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - br, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ br;
    assign bo = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with a start/busy/done handshake and results held until the next completion.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 low result bits; the last bit joins them straight from the cell.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_ext;
    logic             br_q;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt_q;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;

    full_subtractor u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .br (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // New difference bit enters on the MSB side; on the last RUN cycle this is the full result.
    always_comb begin
        res_ext = {cell_d, res_sr};
        accept  = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // Sequencer, serial datapath and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            br_q    <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Operand MSBs are kept aside because the shift registers lose them.
                a_sr    <= a;
                b_sr    <= b;
                br_q    <= bin;
                a_msb   <= a[WIDTH-1];
                b_msb   <= b[WIDTH-1];
                res_sr  <= '0;
                cnt_q   <= '0;
                busy    <= 1'b1;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        res_sr <= res_ext[WIDTH-1:1];
                        br_q   <= cell_bo;
                        a_sr   <= a_sr >> 1;
                        b_sr   <= b_sr >> 1;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_q <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            diff    <= res_ext;
                            bout    <= cell_bo;
                            ovf     <= (a_msb != b_msb) && (cell_d != a_msb);
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor with a start/busy/done handshake: computes diff = a - b - bin, LSB first, one bit per clock.
- Iterates a single full-subtractor cell with a registered borrow.
- Complements the combinational full_adder datapath: the subtract direction, built sequentially for area-constrained arithmetic paths.
- Consumed by any controller that issues one operation and waits for done.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block can accept.
- a  input  WIDTH  minuend, captured in the accept cycle.
- b  input  WIDTH  subtrahend, captured in the accept cycle.
- bin  input  1  borrow-in, captured in the accept cycle.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; results are valid from this cycle onward.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow out; 1 iff unsigned a < b + bin.
- ovf  output  1  signed overflow flag.

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- Reset values: busy=0, done=0, diff=0, bout=0, ovf=0; internal state IDLE, bit counter 0, borrow register 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture a, b, bin into shift registers; clear counter; go to RUN.
  - start=0 -> stay in IDLE.
- RUN (busy=1):
  - Each cycle, feed bit 0 of the a/b shift registers and the borrow register into full_subtractor.
  - Shift the difference bit into the result shift register MSB-side; register the cell's borrow.
  - Shift operands right; increment counter.
  - After exactly WIDTH RUN cycles, go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - diff/bout/ovf load from internal registers in this cycle and hold until the next DONE.
  - Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accept).
- Latency: accept at cycle 0 -> done high at cycle WIDTH+1. Back-to-back throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored: no queuing, no effect on the operation in progress.
- Arithmetic rules:
  - Cell: d = x ^ y ^ br; bo = (~x & y) | (~(x ^ y) & br).
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands.
  - Width wrap is modulo 2^WIDTH; the counter is $clog2(WIDTH)+1 bits with no wrap inside RUN.
- Inputs a, b and bin may change freely after the accept cycle; the results must be unaffected.
- rst during RUN or DONE:
  - Next cycle is IDLE with all outputs at reset values.
  - No done pulse for the aborted operation.
  - rst has priority over start.
- Outputs diff/bout/ovf never show partial results.

Decomposition:
- Shared package (arith_pkg):
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH.
- One sub-module: full_subtractor (ports x, y, br -> d, bo), purely combinational, in its own file with its own directed bench covering all 8 input combinations.

Test Plan:
- a=0x05, b=0x03, bin=0, start at cycle 0 -> done at cycle 9; diff=0x02, bout=0, ovf=0; busy high on cycles 1-8.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Interference: start pulsed at cycle 4 with a=0xAA while busy -> ignored; first result unchanged; no extra done. rst at cycle 5 of a fresh operation -> busy=0 and outputs 0 at cycle 6; no done pulse.
- Back-to-back: start held high in the done cycle with a=0x10, b=0x01 -> second done exactly 9 cycles later with diff=0x0F; first result held until then.
